// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two request/ack masters onto one synchronous-read RAM port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 wins ties.
module mem_arbiter #(
  parameter int              AW      = 16,
  parameter int              DW      = 16,
  parameter int              DEPTH   = 256,
  parameter logic [DW-1:0]   BADDATA = 'h0599
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          grant_q, we_q, in_range_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          ack0_q, ack1_q, err0_q, err1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          req_any, tie_win, win_d, win_we, win_in_range;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q;
  assign tie_win = ~last_grant_q;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    req_any      = r0_req | r1_req;
    win_d        = r0_req ? (r1_req & tie_win) : 1'b1;
    win_we       = win_d ? r1_we    : r0_we;
    win_addr     = win_d ? r1_addr  : r0_addr;
    win_wdata    = win_d ? r1_wdata : r0_wdata;
    win_in_range = {1'b0, win_addr} < DEPTH_LIM;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_any) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      // strobes are single-cycle unless a state below raises them
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            grant_q     <= win_d;
            we_q        <= win_we;
            in_range_q  <= win_in_range;
            mem_en_q    <= win_in_range;
            mem_we_q    <= win_in_range & win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
          end
        end
        S_CAPTURE: begin
          if (grant_q) begin
            if (!we_q) rdata1_q <= in_range_q ? mem_rdata : BADDATA;
            err1_q <= ~in_range_q;
            ack1_q <= 1'b1;
          end else begin
            if (!we_q) rdata0_q <= in_range_q ? mem_rdata : BADDATA;
            err0_q <= ~in_range_q;
            ack0_q <= 1'b1;
          end
        end
        S_ACK: begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_grant_q <= grant_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign r0_err    = err0_q;
  assign r1_err    = err1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;

endmodule
